// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the six-stage pipeline sequencing controller:
// per-stage stop levels, reset level, merged stall encodings, controller FSM
// states, default ERET code and exception vector, and the stall-merge helper.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Per-stage stop levels and the reset active level.
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    // Merged stall vectors (bit0 PC ... bit5 WB). A stalled stage also stops
    // every stage in front of it. WB is never stopped.
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000E;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // The deepest requesting stage wins, since its stall covers all earlier ones.
    function automatic logic [5:0] merge_stall(input logic req_if, input logic req_id,
                                               input logic req_ex, input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// -----------------------------------------------------------------------------
// pipe_perf_cnt
// Saturating stall-cycle counter plus a stall watchdog.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stalled           1 = this cycle is a RUN-state stalled cycle
//   clr               clears counter, consecutive count and watchdog flag
//   stall_cycles_o    saturating count of stalled cycles
//   wdog_o            sticky flag: WDOG_LIMIT consecutive stalled cycles seen
// -----------------------------------------------------------------------------
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stalled,
    input  logic        clr,
    output logic [31:0] stall_cycles_o,
    output logic        wdog_o
);

    localparam int unsigned      CW    = $clog2(WDOG_LIMIT + 1);
    localparam logic [CW-1:0]    LIMIT = CW'(WDOG_LIMIT);

    logic [31:0]   cnt_q, cnt_d;
    logic [CW-1:0] consec_q, consec_d;
    logic          wdog_q, wdog_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        consec_d = '0;
        wdog_d   = wdog_q;
        if (stalled) begin
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
            consec_d = (consec_q == LIMIT) ? LIMIT : consec_q + CW'(1);
        end
        if (consec_d == LIMIT) wdog_d = 1'b1;
        // Clear wins over a same-cycle increment.
        if (clr) begin
            cnt_d    = '0;
            consec_d = '0;
            wdog_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge value of its neighbours, exactly like the hardware.
        if (rst == RST_ENABLE) begin
            cnt_q    <= '0;
            consec_q <= '0;
            wdog_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
            wdog_q   <= wdog_d;
        end
    end

    assign stall_cycles_o = cnt_q;
    assign wdog_o         = wdog_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Sequencing controller for the PC/IF/ID/EX/MEM/WB pipeline: merges stall
// requests, sequences exception/ERET flushes (RUN -> FLUSH -> HOLD -> RUN),
// supplies the redirect PC and keeps stall performance counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallreq_{if,id,ex,mem}_i per-stage stall requests
//   excepttype_i             nonzero = exception pending in MEM
//   cp0_epc_i                ERET return address
//   perf_clr_i               clears stall counter and watchdog
//   stall_o                  per-stage stop vector (bit0 PC ... bit5 WB)
//   flush_o                  clears all pipeline registers (registered)
//   new_pc_o                 redirect target, valid while flush_o=1
//   stall_cycles_o, wdog_o   performance counter and sticky watchdog
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE   = ERET_CODE_DEF,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned WDOG_LIMIT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        perf_clr_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [31:0] stall_cycles_o,
    output logic        wdog_o
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        run_stalled;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        flush_d  = 1'b0;
        new_pc_d = new_pc_q;
        case (state_q)
            ST_RUN: begin
                // An exception waits while MEM itself is stalled on the data bus.
                if ((excepttype_i != 32'd0) && !stallreq_mem_i) begin
                    state_d  = ST_FLUSH;
                    flush_d  = 1'b1;
                    new_pc_d = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                end
            end
            ST_FLUSH: begin
                state_d = ST_HOLD;
                hold_d  = HOLD_INIT;
            end
            ST_HOLD: begin
                if (hold_q <= 4'd1) begin
                    state_d = ST_RUN;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q  <= ST_RUN;
            hold_q   <= 4'd0;
            flush_q  <= 1'b0;
            new_pc_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            flush_q  <= flush_d;
            new_pc_q <= new_pc_d;
        end
    end

    // Stall vector is combinational so a request stops the pipe in the same
    // cycle; it is forced quiet while reset is asserted.
    always_comb begin
        stall_o = STALL_NONE;
        if (rst != RST_ENABLE) begin
            case (state_q)
                ST_RUN:  stall_o = merge_stall(stallreq_if_i, stallreq_id_i,
                                               stallreq_ex_i, stallreq_mem_i);
                ST_HOLD: stall_o = STALL_IF;
                default: stall_o = STALL_NONE;
            endcase
        end
    end

    // Every nonzero merged encoding stops the PC, so bit0 marks a stalled cycle.
    assign run_stalled = (state_q == ST_RUN) && (stall_o[0] == STOP);

    assign flush_o  = flush_q;
    assign new_pc_o = new_pc_q;

    pipe_perf_cnt #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_perf (
        .clk            (clk),
        .rst            (rst),
        .stalled        (run_stalled),
        .clr            (perf_clr_i),
        .stall_cycles_o (stall_cycles_o),
        .wdog_o         (wdog_o)
    );

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Sequencing controller for the six-stage pipeline (PC, IF, ID, EX, MEM, WB).
- Merges per-stage stall requests into the stall[5:0] vector consumed by every inter-stage register, including the MEM/WB register.
- Sequences exception/ERET flushes through a small FSM and supplies the redirect PC.
- Keeps a stall-cycle performance counter and a stall watchdog.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for every non-ERET exception
ERET_CODE, 32'h0000_000E, excepttype_i value meaning ERET
HOLD_CYCLES, 2, cycles PC/IF are held after a flush (1..15)
WDOG_LIMIT, 1024, consecutive stalled cycles that trip the watchdog (≥2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if_i  in  1  fetch-bus wait
stallreq_id_i  in  1  load-use hazard
stallreq_ex_i  in  1  multi-cycle ALU busy
stallreq_mem_i  in  1  data-bus wait
excepttype_i  in  32  from MEM stage; nonzero = exception pending
cp0_epc_i  in  32  EPC from CP0
perf_clr_i  in  1  clears counter and watchdog flag
stall_o  out  6  bit0 PC … bit5 WB; 1 = stop
flush_o  out  1  clear all pipeline registers
new_pc_o  out  32  redirect target, valid while flush_o=1
stall_cycles_o  out  32  count of stalled cycles
wdog_o  out  1  sticky watchdog flag

Behaviour:
- Reset values: stall_o=0, flush_o=0, new_pc_o=0, stall_cycles_o=0, wdog_o=0, state=RUN, hold/consecutive counters=0.
- Stall merge in RUN is combinational from the request inputs. Highest requester wins:
  - mem → 6'b011111
  - ex → 6'b001111
  - id → 6'b000111
  - if → 6'b000011
  - none → 0
  - stall[5] is never driven to 1.
- FSM states:
  - RUN:
    - excepttype_i≠0 and stallreq_mem_i=0 → FLUSH on the next edge; new_pc_o is registered in the same edge.
    - new_pc_o = cp0_epc_i if excepttype_i==ERET_CODE, otherwise EXC_VECTOR.
    - excepttype_i≠0 with stallreq_mem_i=1: exception deferred; stall merge applies; re-evaluated each cycle.
  - FLUSH (exactly 1 cycle):
    - flush_o=1, stall_o=0, all stall requests ignored.
    - Go to HOLD and load the hold counter with HOLD_CYCLES.
  - HOLD:
    - flush_o=0, stall_o=6'b000011, regardless of requests.
    - Counter decrements each cycle; at 1 → RUN.
    - excepttype_i ignored.
- Latency: exception seen in cycle N → flush_o=1 in N+1 → HOLD for N+2..N+1+HOLD_CYCLES → RUN in N+2+HOLD_CYCLES.
- flush_o and new_pc_o are registered. new_pc_o holds its value outside FLUSH.
- stall_cycles_o:
  - +1 on each edge where the RUN-state stall_o≠0.
  - Saturates at 32'hFFFF_FFFF.
  - HOLD cycles are not counted.
- Watchdog:
  - Consecutive counter +1 per RUN stalled cycle; reset to 0 on any non-stalled cycle or on FLUSH.
  - Reaching WDOG_LIMIT sets wdog_o, which is sticky.
  - Counter stops at WDOG_LIMIT.
- perf_clr_i clears stall_cycles_o, wdog_o and the consecutive counter. Clear wins over increment in the same cycle.
- rst asserted in any state (including mid-HOLD) returns all state to reset values on the next edge.

Decomposition:
- Shared defines file:
  - stall encodings (STALL_NONE/IF/ID/EX/MEM)
  - FSM state codes
  - ERET code
  - exception vector
  - existing Stop/NoStop and RstEnable macros
- One sub-module, pipe_perf_cnt: saturating 32-bit stall counter plus watchdog; inputs stalled, clr.

Test Plan:
- Reset: hold rst 3 cycles with all requests=1 and excepttype_i=1 → stall_o=0, flush_o=0, new_pc_o=0, counters 0.
- Priority: id=1 and ex=1 → stall_o=6'b001111; add mem=1 → 6'b011111; only if=1 → 6'b000011; stall_cycles_o=3 after those 3 cycles.
- Exception: excepttype_i=32'h1 at cycle N → flush_o=1 and new_pc_o=0x20 at N+1; stall_o=6'b000011 at N+2,N+3; stall_o=0 at N+4 (HOLD_CYCLES=2).
- ERET deferred: excepttype_i=0xE, cp0_epc_i=0x8000_1000, mem=1 for 4 cycles → stall_o=6'b011111, no flush; mem drops → flush_o=1 next cycle with new_pc_o=0x8000_1000.
- Watchdog (WDOG_LIMIT=8): ex=1 for 7 cycles → wdog_o=0; 8th → wdog_o=1; remains 1 after ex=0; perf_clr_i=1 → wdog_o=0 and stall_cycles_o=0.
- Mid-HOLD reset: rst during HOLD → next cycle stall_o=0, RUN; a fresh exception flushes normally.
